// File: rtl/neuron_accumulator_pkg.sv
// Shared definitions for the neuron accumulation layer: FSM encoding and
// accumulator sizing.
package neuron_accumulator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_BIAS  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Wide enough to hold num_inputs full-scale products plus one bias term
  // without wrapping.
  function automatic int unsigned acc_width(int unsigned data_width,
                                            int unsigned num_inputs);
    return data_width + $clog2(num_inputs + 1) + 1;
  endfunction

endpackage

// File: rtl/neuron_accumulator_sat_clamp.sv
// Combinational signed saturation from IN_WIDTH down to OUT_WIDTH bits.
module sat_clamp #(
  parameter int unsigned IN_WIDTH  = 38,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  in_i,
  output logic [OUT_WIDTH-1:0] out_o
);

  localparam int unsigned HeadW = IN_WIDTH - OUT_WIDTH + 1;

  // The value fits when every bit from the output sign bit upward agrees.
  logic [HeadW-1:0] head;
  logic             fits;

  assign head = in_i[IN_WIDTH-1 -: HeadW];
  assign fits = (&head) || ~(|head);

  // Pass through in range, otherwise clamp toward the sign of the input.
  always_comb begin
    if (fits) begin
      out_o = in_i[OUT_WIDTH-1:0];
    end else if (in_i[IN_WIDTH-1]) begin
      out_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      out_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Sums NUM_INPUTS signed product beats per frame, adds a per-frame bias and
// emits the saturated result as a one-cycle strobe.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] in_bias,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned AccW = acc_width(DATA_WIDTH, NUM_INPUTS);
  localparam int unsigned CntW = $clog2(NUM_INPUTS + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(NUM_INPUTS);

  state_t                state_q, state_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] bias_q, bias_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  beat;
  logic [AccW-1:0]       data_ext;
  logic [AccW-1:0]       bias_ext;
  logic [DATA_WIDTH-1:0] sat_out;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign beat     = in_valid && in_ready;
  assign data_ext = {{(AccW-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign bias_ext = {{(AccW-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  sat_clamp #(
    .IN_WIDTH (AccW),
    .OUT_WIDTH(DATA_WIDTH)
  ) u_sat_clamp (
    .in_i (acc_q),
    .out_o(sat_out)
  );

  // Frame sequencing: load on first beat, accumulate, add bias, publish.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    bias_d      = bias_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          acc_d   = data_ext;
          bias_d  = in_bias;
          count_d = CntOne;
          state_d = (CntLast == CntOne) ? ST_BIAS : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          acc_d   = acc_q + data_ext;
          count_d = count_q + CntOne;
          if (count_d == CntLast) begin
            state_d = ST_BIAS;
          end
        end
      end
      ST_BIAS: begin
        acc_d   = acc_q + bias_ext;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Clamp happens only here; acc itself never saturates.
        out_valid_d = 1'b1;
        out_data_d  = sat_out;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator: directed frames with literal
// expectations plus a long randomized run against a frame-level model.
module tb_neuron_accumulator;

  localparam int DW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_bias = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;

  neuron_accumulator #(
    .DATA_WIDTH(DW),
    .NUM_INPUTS(N)
  ) dut (
    .clk      (clk),
    .rstn     (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_bias  (in_bias),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level reference: collect N accepted beats, then two cycles where
  // nothing is accepted, then one result strobe carrying clamp(sum + bias).
  longint        m_sum;
  longint        m_bias;
  int            m_cnt;
  int            m_gap;
  logic          m_ov;
  logic [DW-1:0] m_od;

  function automatic logic [DW-1:0] clampv(input longint v);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (v > hi) return hi[DW-1:0];
    if (v < lo) return lo[DW-1:0];
    return v[DW-1:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum  <= 0;
      m_bias <= 0;
      m_cnt  <= 0;
      m_gap  <= 0;
      m_ov   <= 1'b0;
      m_od   <= '0;
    end else begin
      m_ov <= 1'b0;
      if (m_gap == 2) begin
        m_gap <= 1;
      end else if (m_gap == 1) begin
        m_gap <= 0;
        m_ov  <= 1'b1;
        m_od  <= clampv(m_sum + m_bias);
      end else if (in_valid) begin
        if (m_cnt == 0) begin
          m_sum  <= longint'($signed(in_data));
          m_bias <= longint'($signed(in_bias));
        end else begin
          m_sum <= m_sum + longint'($signed(in_data));
        end
        if (m_cnt + 1 == N) begin
          m_cnt <= 0;
          m_gap <= 2;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("in_ready", {63'd0, in_ready}, {63'd0, m_gap == 0});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    check("out_data", {32'd0, out_data}, {32'd0, m_od});
  end

  // Result log for the directed tests.
  logic [DW-1:0] res_q[$];
  int            cyc_q[$];

  always @(negedge clk) begin
    if (out_valid) begin
      res_q.push_back(out_data);
      cyc_q.push_back(cycle);
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [DW-1:0] b);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_bias  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  task automatic clear_log();
    res_q.delete();
    cyc_q.delete();
  endtask

  function automatic logic [DW-1:0] rnd_val();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6) return DW'($urandom_range(0, 2000) - 1000);
    if (r == 6) return DW'(32'h7FFF_FFF0 + $urandom_range(0, 15));
    if (r == 7) return DW'(32'h8000_0000 + $urandom_range(0, 15));
    return DW'($urandom);
  endfunction

  initial begin
    // Power-on reset.
    #1 rst = 1'b1;
    #2;
    check("por_out_valid", {63'd0, out_valid}, 64'd0);
    check("por_out_data", {32'd0, out_data}, 64'd0);
    #10 rst = 1'b0;
    #1;
    check("por_ready", {63'd0, in_ready}, 64'd1);

    // 1,2,3,4 with bias 10 -> 20, strobe two edges after beat 4.
    clear_log();
    drive(1'b1, DW'(1), DW'(10));
    drive(1'b1, DW'(2), DW'(55));
    drive(1'b1, DW'(3), DW'(66));
    drive(1'b1, DW'(4), DW'(77));
    drive(1'b0, '0, '0);
    check("lat_edge0", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("lat_edge1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("lat_edge2_valid", {63'd0, out_valid}, 64'd1);
    check("lat_edge2_data", {32'd0, out_data}, 64'd20);
    @(negedge clk);
    check("lat_edge3_valid", {63'd0, out_valid}, 64'd0);
    check("lat_hold_data", {32'd0, out_data}, 64'd20);
    idle(2);

    // Idle gaps inside a frame do not count as beats.
    clear_log();
    drive(1'b1, DW'(-5), DW'(-4));
    drive(1'b1, DW'(7), DW'(9));
    idle(3);
    drive(1'b1, DW'(-1), DW'(9));
    drive(1'b1, DW'(3), DW'(9));
    idle(5);
    check("gap_count", res_q.size(), 64'd1);
    if (res_q.size() == 1) check("gap_data", {32'd0, res_q[0]}, 64'd0);

    // Saturation at both rails.
    clear_log();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h7FFF_FFFF, DW'(1));
    idle(4);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h8000_0000, DW'(-1));
    idle(5);
    check("sat_count", res_q.size(), 64'd2);
    if (res_q.size() == 2) begin
      check("sat_pos", {32'd0, res_q[0]}, 64'h7FFF_FFFF);
      check("sat_neg", {32'd0, res_q[1]}, 64'h8000_0000);
    end

    // Continuous valid, 12 offers: beats during BIAS/DONE are dropped.
    clear_log();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, DW'(i + 1), DW'(100));
      check("stream_ready", {63'd0, in_ready},
            {63'd0, !(i == 4 || i == 5 || i == 10 || i == 11)});
    end
    idle(5);
    check("stream_count", res_q.size(), 64'd2);
    if (res_q.size() == 2) begin
      check("stream_f0", {32'd0, res_q[0]}, 64'd110);
      check("stream_f1", {32'd0, res_q[1]}, 64'd134);
      check("stream_spacing", cyc_q[1] - cyc_q[0], 64'd6);
    end

    // Reset mid-frame after 2 beats, then a fresh 1,1,1,1 frame.
    clear_log();
    drive(1'b1, DW'(1), DW'(0));
    drive(1'b1, DW'(1), DW'(0));
    drive(1'b0, '0, '0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_data", {32'd0, out_data}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(1);
    in_bias  = DW'(0);
    #1;
    check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(1), DW'(0));
    idle(6);
    check("post_rst_count", res_q.size(), 64'd1);
    if (res_q.size() == 1) check("post_rst_data", {32'd0, res_q[0]}, 64'd4);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 70, rnd_val(), rnd_val());
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of signed two's-complement operands and result.
REQ-002 SHALL have parameter NUM_INPUTS, default 4, meaning products per neuron frame; legal range >= 1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-high (asserted = 1); the name is kept for consistency with the codebase.
REQ-005 SHALL have port in_valid  input  1  product beat present on in_data.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  signed product term from the upstream multiply/alignment stage.
REQ-007 SHALL have port in_bias  input  DATA_WIDTH  signed bias, delay-aligned upstream, sampled with the first beat of a frame.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port out_valid  output  1  single-cycle result strobe.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  saturated sum of the frame plus bias, held until the next result.

Function
REQ-011 SHALL accept a beat when in_valid = 1 and in_ready = 1 on the same rising edge; other cycles are ignored.
REQ-012 SHALL implement states IDLE, ACCUM, BIAS, DONE.
REQ-013 In IDLE, an accepted beat SHALL load acc = sign-extended in_data, capture in_bias, set count = 1, and go to ACCUM; if NUM_INPUTS = 1, it SHALL go directly to BIAS.
REQ-014 In ACCUM, each accepted beat SHALL add sign-extended in_data to acc and increment count; the beat making count = NUM_INPUTS SHALL move to BIAS.
REQ-015 Cycles without a beat (in_valid = 0) SHALL leave acc and count unchanged and SHALL NOT end or abort the frame.
REQ-016 BIAS SHALL add the captured bias to acc for one cycle, then go to DONE.
REQ-017 DONE SHALL assert out_valid for exactly one cycle and update out_data, then go to IDLE.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in BIAS and DONE; beats offered in BIAS or DONE are dropped.
REQ-019 Latency: out_valid SHALL assert on the 2nd rising edge after the edge accepting the final beat.
REQ-020 Back-to-back throughput SHALL be one frame per NUM_INPUTS + 2 cycles minimum.
REQ-021 acc SHALL be DATA_WIDTH + clog2(NUM_INPUTS+1) + 1 bits wide, so no intermediate overflow is possible.
REQ-022 out_data SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; the clamp applies only at the DONE update.
REQ-023 out_data SHALL hold its value whenever out_valid = 0.

Reset
REQ-024 Assertion of rstn SHALL immediately force state = IDLE, acc = 0, count = 0, captured bias = 0, out_valid = 0, out_data = 0, and in_ready = 1 after release.
REQ-025 Reset mid-frame SHALL discard the partial frame; no out_valid SHALL be produced for it.
REQ-026 The first edge after deassertion SHALL be able to accept a beat.

Structure
REQ-027 The state enum and the accumulator-width function SHALL live in the shared DQN package.
REQ-028 Saturation SHALL be a sub-module sat_clamp (parameters IN_WIDTH, OUT_WIDTH; combinational), which is reusable by other layer blocks.
REQ-029 No memories SHALL be used; all storage is flops.

Verification (DATA_WIDTH = 32, NUM_INPUTS = 4)
REQ-030 Reset: assert rstn mid-run -> out_valid = 0, out_data = 0 immediately; in_ready = 1 after release.
REQ-031 Beats 1, 2, 3, 4 on consecutive cycles with bias 10 -> out_data = 20 with a one-cycle out_valid exactly 2 edges after beat 4.
REQ-032 Beats -5, 7, gap of 3 idle cycles, then -1, 3 with bias -4 -> out_data = 0; idle cycles do not count.
REQ-033 Four beats of 0x7FFFFFFF with bias 1 -> out_data = 0x7FFFFFFF; four beats of 0x80000000 with bias -1 -> out_data = 0x80000000.
REQ-034 in_valid held high continuously with 12 beats supplied -> in_ready is low in BIAS/DONE; exactly the beats accepted while in_ready = 1 are used; frames are separated by 6-cycle spacing.
REQ-035 Reset after 2 beats, then a fresh frame 1, 1, 1, 1 with bias 0 -> single out_valid with out_data = 4.
